// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared state type and width helpers for the conv layer sequencer
package conv_seq_pkg;

  typedef enum logic [2:0] {
    eIDLE,
    eSTART,
    eRUN,
    eWAIT_IDLE,
    eDONE
  } seq_state_e;

  // Bits needed to hold every value 0..max_val.
  function automatic int count_bits(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_counter.sv
// rtl/seq_counter.sv - modulo-MAX up-counter with clear, enable and terminal-count flag
module seq_counter #(
  parameter int MAX = 2,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  // tc_o marks the last value before wrap; the caller qualifies it with en_i.
  assign tc_o = (count_o == W'(MAX - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      count_o <= '0;
    end else if (en_i) begin
      count_o <= tc_o ? '0 : count_o + 1'b1;
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// rtl/conv_layer_sequencer.sv - runs one conv layer over a frame burst and owns its kernel-RAM write port
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int WORD_SIZE          = 16,
  parameter int INPUT_LAYER_HEIGHT = 64,
  parameter int KERNEL_WIDTH       = 2,
  parameter int KERNEL_HEIGHT      = 5,
  parameter int OUTPUTS_PER_FRAME  = 60,
  parameter int N_CONVOLUTIONS     = 4,
  parameter int MAX_FRAMES         = 255,
  localparam int FRAME_BITS        = count_bits(MAX_FRAMES),
  localparam int CFG_BITS          = sel_bits(N_CONVOLUTIONS) + count_bits(KERNEL_WIDTH * KERNEL_HEIGHT)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  run_valid_i,
  output logic                  run_ready_o,
  input  logic [FRAME_BITS-1:0] n_frames_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [CFG_BITS-1:0]   cfg_addr_i,
  input  logic [WORD_SIZE-1:0]  cfg_data_i,
  output logic                  conv_start_o,
  input  logic                  conv_ready_i,
  input  logic                  in_hs_i,
  input  logic                  out_hs_i,
  output logic                  w_en_o,
  output logic [CFG_BITS-1:0]   w_addr_o,
  output logic [WORD_SIZE-1:0]  w_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [FRAME_BITS-1:0] frames_done_o
);

  localparam int FRAME_WORDS = KERNEL_WIDTH * INPUT_LAYER_HEIGHT;

  seq_state_e state_q;
  logic [FRAME_BITS-1:0] n_frames_q;
  logic words_full_q, overrun_q;
  logic run_hs, cfg_hs, start_go, cnt_clr;
  logic word_en, word_tc, out_en, out_tc, frame_en, frame_tc;
  logic [count_bits(FRAME_WORDS)-1:0]       word_cnt;
  logic [count_bits(OUTPUTS_PER_FRAME)-1:0] out_cnt;
  logic unused_status;

  assign run_ready_o  = (state_q == eIDLE);
  assign cfg_ready_o  = (state_q == eIDLE) && !run_valid_i;
  assign run_hs       = run_valid_i && run_ready_o;
  assign cfg_hs       = cfg_valid_i && cfg_ready_o;
  assign start_go     = (state_q == eSTART) && conv_ready_i;
  assign conv_start_o = start_go;
  assign busy_o       = (state_q != eIDLE);
  assign cnt_clr      = start_go || run_hs;

  // Input words past a full frame are dropped and only flagged.
  assign word_en  = (state_q == eRUN) && in_hs_i && !words_full_q;
  assign out_en   = (state_q == eRUN) && out_hs_i;
  assign frame_en = out_en && out_tc && !frame_tc;

  assign unused_status = ^{word_cnt, out_cnt, overrun_q};

  seq_counter #(.MAX(FRAME_WORDS)) u_word_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .clr_i(cnt_clr), .en_i(word_en),
    .count_o(word_cnt), .tc_o(word_tc)
  );

  seq_counter #(.MAX(OUTPUTS_PER_FRAME)) u_out_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .clr_i(cnt_clr), .en_i(out_en),
    .count_o(out_cnt), .tc_o(out_tc)
  );

  seq_counter #(.MAX(MAX_FRAMES + 1), .W(FRAME_BITS)) u_frame_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .clr_i(run_hs), .en_i(frame_en),
    .count_o(frames_done_o), .tc_o(frame_tc)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= eIDLE;
      n_frames_q   <= '0;
      words_full_q <= 1'b0;
      overrun_q    <= 1'b0;
      w_en_o       <= 1'b0;
      w_addr_o     <= '0;
      w_data_o     <= '0;
      done_o       <= 1'b0;
    end else begin
      w_en_o <= cfg_hs;
      done_o <= (state_q == eDONE);
      if (cfg_hs) begin
        w_addr_o <= cfg_addr_i;
        w_data_o <= cfg_data_i;
      end
      if (word_en && word_tc) words_full_q <= 1'b1;
      if ((state_q == eRUN) && in_hs_i && words_full_q) overrun_q <= 1'b1;

      case (state_q)
        eIDLE: begin
          if (run_hs) begin
            n_frames_q <= n_frames_i;
            overrun_q  <= 1'b0;
            state_q    <= (n_frames_i == '0) ? eDONE : eSTART;
          end
        end
        eSTART: begin
          if (conv_ready_i) begin
            words_full_q <= 1'b0;
            state_q      <= eRUN;
          end
        end
        eRUN: begin
          if (out_en && out_tc) state_q <= eWAIT_IDLE;
        end
        eWAIT_IDLE: begin
          if (conv_ready_i) state_q <= (frames_done_o == n_frames_q) ? eDONE : eSTART;
        end
        eDONE:   state_q <= eIDLE;
        default: state_q <= eIDLE;
      endcase
    end
  end

endmodule
